// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind async_receiver: handshakes each byte in, 1-cycle write-to-read latency,
// never back-pressures the receiver (drops when full, sticky overflow). Optional RX_FIFO_HIGH_WATER_EN adds almost_full_o.
module uart_rx_fifo #(
  parameter int ADDR_W     = 4,
  parameter int HIGH_WATER = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_ready_i,
  output logic              rx_clear_o,
  input  logic              pop_i,
  output logic [7:0]        data_o,
  output logic              data_valid_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              overflow_o,
  input  logic              overflow_clr_i
`ifdef RX_FIFO_HIGH_WATER_EN
  ,
  output logic              almost_full_o
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  if (HIGH_WATER < 1 || HIGH_WATER > DEPTH) begin : g_bad_high_water
    $error("uart_rx_fifo: HIGH_WATER must lie in 1..2**ADDR_W");
  end

  typedef enum logic [1:0] {
    CAP_IDLE  = 2'd0,
    CAP_CLEAR = 2'd1,
    CAP_WAIT  = 2'd2
  } cap_state_e;

  cap_state_e state_q, state_d;
  logic       rx_clear_q, rx_clear_d;
  logic       push_req;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;

  logic empty, full, pop_ok, push_ok, drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CAP_IDLE;
      rx_clear_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_clear_q <= rx_clear_d;
    end
  end

  // WAIT holds off until the receiver lowers ready, so one byte yields one push.
  always_comb begin
    state_d    = state_q;
    rx_clear_d = 1'b0;
    push_req   = 1'b0;
    unique case (state_q)
      CAP_IDLE: begin
        if (rx_ready_i) begin
          push_req   = 1'b1;
          rx_clear_d = 1'b1;
          state_d    = CAP_CLEAR;
        end
      end
      CAP_CLEAR: state_d = CAP_WAIT;
      CAP_WAIT: begin
        if (!rx_ready_i) state_d = CAP_IDLE;
      end
      default: state_d = CAP_IDLE;
    endcase
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_CNT);

  // Empty is judged before the push, so a pop into an empty FIFO is ignored even if a byte lands.
  assign pop_ok  = pop_i && !empty;
  assign push_ok = push_req && (!full || pop_i);
  assign drop    = push_req && full && !pop_i;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clr_i) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= rx_data_i;
  end

  assign rx_clear_o   = rx_clear_q;
  assign data_o       = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign data_valid_o = !empty;
  assign count_o      = count_q;
  assign full_o       = full;
  assign overflow_o   = overflow_q;

`ifdef RX_FIFO_HIGH_WATER_EN
  logic almost_full_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= (count_q >= (ADDR_W+1)'(HIGH_WATER));
    end
  end

  assign almost_full_o = almost_full_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed test-plan sequences plus randomized receiver/consumer traffic vs a queue model.
module tb_uart_rx_fifo;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int HW     = 12;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      rx_data = 8'h00;
  logic            rx_ready = 1'b0;
  logic            rx_clear;
  logic            pop = 1'b0;
  logic [7:0]      data;
  logic            data_valid;
  logic [ADDR_W:0] count;
  logic            full;
  logic            overflow;
  logic            overflow_clr = 1'b0;
`ifdef RX_FIFO_HIGH_WATER_EN
  logic            almost_full;
`endif

  always #5 clk = ~clk;

  uart_rx_fifo #(.ADDR_W(ADDR_W), .HIGH_WATER(HW)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data_i      (rx_data),
    .rx_ready_i     (rx_ready),
    .rx_clear_o     (rx_clear),
    .pop_i          (pop),
    .data_o         (data),
    .data_valid_o   (data_valid),
    .count_o        (count),
    .full_o         (full),
    .overflow_o     (overflow),
    .overflow_clr_i (overflow_clr)
`ifdef RX_FIFO_HIGH_WATER_EN
    ,
    .almost_full_o  (almost_full)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: byte queue, sticky flag, and capture eligibility by cycle age.
  logic [7:0] m_q[$];
  bit         m_ov;
  bit         m_clr;
  bit         m_af;
  bit         m_armed;
  int         m_age;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ov    = 1'b0;
    m_clr   = 1'b0;
    m_af    = 1'b0;
    m_armed = 1'b1;
    m_age   = 0;
  endtask

  task automatic check_outputs();
    int sz;
    sz = m_q.size();
    check_eq("count", 32'(count), 32'(sz));
    check_eq("valid", 32'(data_valid), 32'(sz != 0));
    check_eq("data", 32'(data), (sz != 0) ? 32'(m_q[0]) : 32'h0);
    check_eq("full", 32'(full), 32'(sz == DEPTH));
    check_eq("overflow", 32'(overflow), 32'(m_ov));
    check_eq("rx_clear", 32'(rx_clear), 32'(m_clr));
`ifdef RX_FIFO_HIGH_WATER_EN
    check_eq("almost_full", 32'(almost_full), 32'(m_af));
`endif
  endtask

  // Called at a negedge with inputs already set: check, advance model, run one clock.
  task automatic step();
    int sz;
    bit cap, drop, pop_eff;
    check_outputs();
    sz      = m_q.size();
    cap     = m_armed && rx_ready;
    pop_eff = pop && (sz > 0);
    drop    = cap && (sz == DEPTH) && !pop;
    m_af    = (sz >= HW);
    if (pop_eff) void'(m_q.pop_front());
    if (cap && !drop) m_q.push_back(rx_data);
    if (drop) m_ov = 1'b1;
    else if (overflow_clr) m_ov = 1'b0;
    // After a capture the next one needs ready seen low from the second cycle on.
    if (cap) begin
      m_armed = 1'b0;
      m_age   = 0;
    end else if (!m_armed) begin
      m_age++;
      if (m_age >= 2 && !rx_ready) m_armed = 1'b1;
    end
    m_clr = cap;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input bit pop_cap, input bit clr_cap);
    int n;
    rx_data      = b;
    rx_ready     = 1'b1;
    pop          = pop_cap;
    overflow_clr = clr_cap;
    step();
    pop          = 1'b0;
    overflow_clr = 1'b0;
    n = 0;
    while (!rx_clear && n < 8) begin
      step();
      n++;
    end
    check_eq("clear_seen", 32'(rx_clear), 32'h1);
    repeat (hold) step();
    rx_ready = 1'b0;
    step();
    step();
  endtask

  task automatic pop_n(input int n);
    pop = 1'b1;
    repeat (n) step();
    pop = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rstate, gap, hold, pop_pct;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // Single byte, receiver holds ready a while after clear.
    step();
    send_byte(8'h41, 2, 1'b0, 1'b0);
    pop_n(2);

    // Fill, overflow with 0xAA, drain in order.
    for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 0, 1'b0, 1'b0);
    send_byte(8'hAA, 1, 1'b0, 1'b0);
    pop_n(DEPTH + 1);
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    step();

    // Pointer wrap.
    for (int i = 0; i < 10; i++) send_byte(8'(8'h20 + i), 0, 1'b0, 1'b0);
    pop_n(10);
    for (int i = 0; i < 10; i++) send_byte(8'(8'h30 + i), 0, 1'b0, 1'b0);
    pop_n(11);

    // Full with simultaneous push/pop, then set/clear race on a drop.
    for (int i = 0; i < DEPTH; i++) send_byte(8'(8'h50 + i), 0, 1'b0, 1'b0);
    send_byte(8'hC3, 0, 1'b1, 1'b0);
    send_byte(8'hD4, 0, 1'b0, 1'b1);
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    pop_n(DEPTH + 1);

    // Empty with simultaneous push/pop.
    send_byte(8'h9E, 0, 1'b1, 1'b0);
    pop_n(2);

    // Reset in CAP_WAIT with the receiver still holding ready.
    rx_data  = 8'h77;
    rx_ready = 1'b1;
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    step();
    step();
    step();
    rx_ready = 1'b0;
    step();
    step();
    pop_n(2);

    // Random receiver timing and consumer rate.
    rstate  = 0;
    gap     = 0;
    hold    = 0;
    pop_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) pop_pct = int'($urandom_range(0, 100));
      case (rstate)
        0: begin
          if (gap > 0) gap--;
          else if ($urandom_range(0, 2) == 0) begin
            rx_data  = 8'($urandom);
            rx_ready = 1'b1;
            rstate   = 1;
          end
        end
        1: begin
          if (rx_clear) begin
            hold   = int'($urandom_range(0, 3));
            rstate = 2;
          end
        end
        default: begin
          if (hold > 0) hold--;
          else begin
            rx_ready = 1'b0;
            gap      = int'($urandom_range(1, 4));
            rstate   = 0;
          end
        end
      endcase
      pop          = (int'($urandom_range(0, 99)) < pop_pct);
      overflow_clr = ($urandom_range(0, 15) == 0);
      step();
    end
    rx_ready     = 1'b0;
    overflow_clr = 1'b0;
    step();
    step();
    pop_n(DEPTH + 2);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
